// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, runs the req/ready handshake to instruction
// memory and holds the IF/ID register, backed by a one-entry skid buffer.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic [5:0]  op_code
);

  typedef enum logic {REQ, SKID} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        drop;
  logic        drop_nxt;
  logic        req_nxt;
  logic [31:0] addr_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] instr_pc_nxt;
  logic        valid_nxt;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        skid_load;
  logic        slot_free;
  logic [31:0] pc_inc;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  assign slot_free = !instr_valid || !stall;
  assign pc_inc    = pc + 32'd4;
  assign pc_plus4  = instr_pc + 32'd4;
  assign op_code   = instr[31:26];

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    drop_nxt     = drop;
    req_nxt      = imem_req;
    addr_nxt     = imem_addr;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    valid_nxt    = instr_valid;
    skid_load    = 1'b0;
    if (redirect) begin
      pc_nxt    = word_align(redirect_pc);
      valid_nxt = 1'b0;
      state_nxt = REQ;
      // An unanswered request must still complete; its data is thrown away later.
      if (state == REQ && imem_req && !imem_ready) begin
        drop_nxt = 1'b1;
      end else begin
        drop_nxt = 1'b0;
        req_nxt  = 1'b1;
        addr_nxt = word_align(redirect_pc);
      end
    end else begin
      if (slot_free) begin
        valid_nxt = 1'b0;
      end
      case (state)
        REQ: begin
          if (!imem_req) begin
            req_nxt  = 1'b1;
            addr_nxt = pc;
          end else if (imem_ready) begin
            if (drop) begin
              drop_nxt = 1'b0;
              addr_nxt = pc;
            end else if (slot_free) begin
              instr_nxt    = imem_rdata;
              instr_pc_nxt = imem_addr;
              valid_nxt    = 1'b1;
              pc_nxt       = pc_inc;
              addr_nxt     = pc_inc;
            end else begin
              skid_load = 1'b1;
              pc_nxt    = pc_inc;
              req_nxt   = 1'b0;
              state_nxt = SKID;
            end
          end
        end
        SKID: begin
          if (slot_free) begin
            instr_nxt    = skid_instr;
            instr_pc_nxt = skid_pc;
            valid_nxt    = 1'b1;
            req_nxt      = 1'b1;
            addr_nxt     = pc;
            state_nxt    = REQ;
          end
        end
        default: state_nxt = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= REQ;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      drop        <= drop_nxt;
      imem_req    <= req_nxt;
      imem_addr   <= addr_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= valid_nxt;
    end
  end

  // Skid contents are only meaningful while in SKID, so they need no reset.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_instr <= imem_rdata;
      skid_pc    <= imem_addr;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: bench-side memory responder, fetch-address model and
// an in-order scoreboard of delivered instructions, plus a wrap-around instance.
module tb_instruction_fetch;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[7:0], 24'h0} ^ a ^ 32'h00A5_0000;
  endfunction

  function automatic logic [31:0] align4(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic [5:0]  op_code;

  logic        req_w;
  logic [31:0] addr_w;
  logic        ready_w;
  logic [31:0] rdata_w;
  logic        stall_w;
  logic        redirect_w;
  logic [31:0] redirect_pc_w;
  logic [31:0] instr_w;
  logic [31:0] instr_pc_w;
  logic [31:0] pc_plus4_w;
  logic        valid_w;
  logic [5:0]  op_code_w;

  assign ready_w       = 1'b1;
  assign stall_w       = 1'b0;
  assign redirect_w    = 1'b0;
  assign redirect_pc_w = 32'd0;
  assign rdata_w       = word_of(addr_w);

  instruction_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr),
    .instr_pc(instr_pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
    .op_code(op_code)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(req_w), .imem_addr(addr_w),
    .imem_ready(ready_w), .imem_rdata(rdata_w), .stall(stall_w),
    .redirect(redirect_w), .redirect_pc(redirect_pc_w), .instr(instr_w),
    .instr_pc(instr_pc_w), .pc_plus4(pc_plus4_w), .instr_valid(valid_w),
    .op_code(op_code_w)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory responder controls
  int          mem_delay = 0;
  int          wait_cnt  = 0;
  logic        mem_off   = 1'b0;
  logic        hold_en   = 1'b0;
  logic [31:0] hold_addr = 32'd0;

  task automatic step();
    @(posedge clk);
    #1;
    if (imem_req && !reset && !mem_off && !(hold_en && imem_addr == hold_addr)) begin
      if (wait_cnt >= mem_delay) begin
        imem_ready = 1'b1;
        imem_rdata = word_of(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        wait_cnt++;
      end
    end else begin
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      if (!imem_req) wait_cnt = 0;
    end
  endtask

  // Scoreboard and fetch-address model, evaluated mid-cycle for the coming edge
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t        sb[$];
  logic        m_drop = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_tgt  = 32'd0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      m_drop = 1'b0;
      m_addr = 32'd0;
    end else begin
      if (instr_valid && !stall && !redirect) begin
        check_val("sb_avail", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_val("sb_pc", instr_pc, e.pc);
          check_val("sb_instr", instr, e.ins);
          check_val("sb_opcode", 32'(op_code), 32'(e.ins[31:26]));
          check_val("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
        end
      end
      if (imem_req) check_val("addr_model", imem_addr, m_addr);
      if (redirect) begin
        sb.delete();
        m_tgt = align4(redirect_pc);
        if (imem_req && !imem_ready) begin
          m_drop = 1'b1;
        end else begin
          m_drop = 1'b0;
          m_addr = m_tgt;
        end
      end else if (imem_req && imem_ready) begin
        if (m_drop) begin
          m_drop = 1'b0;
          m_addr = m_tgt;
        end else begin
          e.pc  = m_addr;
          e.ins = word_of(m_addr);
          sb.push_back(e);
          m_addr = m_addr + 32'd4;
        end
      end
    end
  end

  task automatic do_reset();
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    mem_delay   = 0;
    mem_off     = 1'b0;
    hold_en     = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    stall    = 1'b0;
    redirect = 1'b0;
    mem_off  = 1'b1;
    for (int i = 0; i < 8 && instr_valid; i++) step();
    check_val({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check_val({tag, "_queue"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    imem_ready  = 1'b0;
    imem_rdata  = 32'd0;

    // Reset values and streaming
    do_reset();
    check_val("rst_req", 32'(imem_req), 32'd0);
    check_val("rst_addr", imem_addr, 32'd0);
    check_val("rst_instr", instr, 32'd0);
    check_val("rst_instr_pc", instr_pc, 32'd0);
    check_val("rst_valid", 32'(instr_valid), 32'd0);
    check_val("rst_opcode", 32'(op_code), 32'd0);
    check_val("rst_pc_plus4", pc_plus4, 32'd4);
    check_val("rst_wrap_addr", addr_w, 32'hFFFF_FFF8);
    check_val("rst_wrap_req", 32'(req_w), 32'd0);
    step();
    check_val("t1_first_req", 32'(imem_req), 32'd1);
    check_val("t1_first_addr", imem_addr, 32'd0);
    check_val("t1_first_valid", 32'(instr_valid), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      w = word_of(32'(4 * (k - 1)));
      check_val("t1_addr", imem_addr, 32'(4 * k));
      check_val("t1_valid", 32'(instr_valid), 32'd1);
      check_val("t1_instr_pc", instr_pc, 32'(4 * (k - 1)));
      check_val("t1_opcode", 32'(op_code), 32'(w[31:26]));
    end
    drain("t1_drain");

    // Stall during streaming: skid fill and release
    do_reset();
    step();
    step();
    step();
    check_val("t2_pre_pc", instr_pc, 32'd4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("t2_stall_req", 32'(imem_req), 32'd0);
      check_val("t2_stall_pc", instr_pc, 32'd4);
      check_val("t2_stall_valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    step();
    check_val("t2_rel_pc", instr_pc, 32'd8);
    check_val("t2_rel_req", 32'(imem_req), 32'd1);
    check_val("t2_rel_addr", imem_addr, 32'hC);
    step();
    check_val("t2_next_pc", instr_pc, 32'hC);
    for (int i = 0; i < 4; i++) step();
    drain("t2_drain");

    // Delayed memory response
    do_reset();
    mem_delay = 4;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("t3_wait_req", 32'(imem_req), 32'd1);
      check_val("t3_wait_addr", imem_addr, 32'd0);
      check_val("t3_wait_valid", 32'(instr_valid), 32'd0);
    end
    step();
    check_val("t3_rdy_valid", 32'(instr_valid), 32'd0);
    check_val("t3_rdy_addr", imem_addr, 32'd0);
    step();
    check_val("t3_out_valid", 32'(instr_valid), 32'd1);
    check_val("t3_out_pc", instr_pc, 32'd0);
    check_val("t3_out_addr", imem_addr, 32'd4);
    reset = 1'b1;
    step();
    check_val("t3_midrst_req", 32'(imem_req), 32'd0);
    check_val("t3_midrst_valid", 32'(instr_valid), 32'd0);
    check_val("t3_midrst_addr", imem_addr, 32'd0);

    // Redirect while a request is pending
    do_reset();
    hold_en   = 1'b1;
    hold_addr = 32'h10;
    for (int i = 0; i < 10 && imem_addr != 32'h10; i++) step();
    check_val("t4_reach", imem_addr, 32'h10);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    check_val("t4_hold_addr", imem_addr, 32'h10);
    check_val("t4_hold_req", 32'(imem_req), 32'd1);
    check_val("t4_hold_valid", 32'(instr_valid), 32'd0);
    step();
    check_val("t4_hold2_addr", imem_addr, 32'h10);
    hold_en = 1'b0;
    step();
    check_val("t4_drop_addr", imem_addr, 32'h10);
    check_val("t4_drop_valid", 32'(instr_valid), 32'd0);
    step();
    check_val("t4_tgt_addr", imem_addr, 32'h100);
    check_val("t4_tgt_valid", 32'(instr_valid), 32'd0);
    step();
    check_val("t4_tgt_out_valid", 32'(instr_valid), 32'd1);
    check_val("t4_tgt_out_pc", instr_pc, 32'h100);
    check_val("t4_tgt_out_instr", instr, word_of(32'h100));
    drain("t4_drain");

    // Redirect with skid full, then redirect on a stalled response
    do_reset();
    step();
    step();
    step();
    stall = 1'b1;
    step();
    check_val("t5_skid_req", 32'(imem_req), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    check_val("t5a_addr", imem_addr, 32'h200);
    check_val("t5a_req", 32'(imem_req), 32'd1);
    check_val("t5a_valid", 32'(instr_valid), 32'd0);
    redirect = 1'b0;
    stall    = 1'b0;
    step();
    check_val("t5a_out_valid", 32'(instr_valid), 32'd1);
    check_val("t5a_out_pc", instr_pc, 32'h200);
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0302;
    step();
    check_val("t5b_addr", imem_addr, 32'h300);
    check_val("t5b_valid", 32'(instr_valid), 32'd0);
    check_val("t5b_req", 32'(imem_req), 32'd1);
    redirect = 1'b0;
    stall    = 1'b0;
    step();
    check_val("t5b_out_valid", 32'(instr_valid), 32'd1);
    check_val("t5b_out_pc", instr_pc, 32'h300);
    drain("t5_drain");

    // PC wrap-around on the FFFF_FFF8 instance
    do_reset();
    step();
    check_val("t6_addr0", addr_w, 32'hFFFF_FFF8);
    check_val("t6_req0", 32'(req_w), 32'd1);
    step();
    check_val("t6_addr1", addr_w, 32'hFFFF_FFFC);
    check_val("t6_pc1", instr_pc_w, 32'hFFFF_FFF8);
    step();
    w = word_of(32'hFFFF_FFFC);
    check_val("t6_addr2", addr_w, 32'h0000_0000);
    check_val("t6_pc2", instr_pc_w, 32'hFFFF_FFFC);
    check_val("t6_pc_plus4", pc_plus4_w, 32'h0000_0000);
    check_val("t6_opcode", 32'(op_code_w), 32'(w[31:26]));
    step();
    check_val("t6_addr3", addr_w, 32'h0000_0004);
    reset = 1'b1;
    step();
    check_val("t6_rst_addr", addr_w, 32'hFFFF_FFF8);
    check_val("t6_rst_req", 32'(req_w), 32'd0);
    check_val("t6_rst_valid", 32'(valid_w), 32'd0);
    reset = 1'b0;
    step();
    check_val("t6_restart_addr", addr_w, 32'hFFFF_FFF8);
    check_val("t6_restart_req", 32'(req_w), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
